// File: rtl/fpu_addsub_pkg.sv
// Shared widths, field slices and constants for the FP add/sub datapath.
package fpu_addsub_pkg;

   localparam int unsigned EW       = 8;
   localparam int unsigned SW       = 23;
   localparam int unsigned SWR      = SW + 3;
   localparam int unsigned EWR      = 5;
   localparam int unsigned DW       = 1 + EW + SW;
   localparam int unsigned DIFF_W   = EW + 1;

   localparam int unsigned SIGN_BIT = EW + SW;
   localparam int unsigned EXP_HI   = EW + SW - 1;
   localparam int unsigned EXP_LO   = SW;
   localparam int unsigned MANT_HI  = SW - 1;
   localparam int unsigned MANT_LO  = 0;

   localparam logic LEFT  = 1'b1;
   localparam logic RIGHT = 1'b0;

   // Hidden bit on top, guard and round bits cleared below.
   function automatic logic [SWR-1:0] mant_ext(input logic [SW-1:0] m);
      return {1'b1, m, 2'b00};
   endfunction

endpackage

// File: rtl/exp_align_stage_if.sv
// Operand-in / aligned-operands-out handshake bundle of the exponent-alignment stage.
interface exp_align_stage_if;
   import fpu_addsub_pkg::*;

   logic            load_i;
   logic            ready_o;
   logic            Op_i;
   logic [DW-1:0]   Data_A_i;
   logic [DW-1:0]   Data_B_i;
   logic            valid_o;
   logic            ready_i;
   logic [EW-1:0]   Major_Exp_o;
   logic [SWR-1:0]  Major_Mant_o;
   logic [SWR-1:0]  Shift_Data_o;
   logic [EWR-1:0]  Shift_Value_o;
   logic            Left_Right_o;
   logic            Sat_o;
   logic            Swap_o;
   logic            Sign_o;
   logic            Eff_Sub_o;

   modport master (
      output load_i, Op_i, Data_A_i, Data_B_i, ready_i,
      input  ready_o, valid_o, Major_Exp_o, Major_Mant_o, Shift_Data_o, Shift_Value_o,
             Left_Right_o, Sat_o, Swap_o, Sign_o, Eff_Sub_o
   );

   modport slave (
      input  load_i, Op_i, Data_A_i, Data_B_i, ready_i,
      output ready_o, valid_o, Major_Exp_o, Major_Mant_o, Shift_Data_o, Shift_Value_o,
             Left_Right_o, Sat_o, Swap_o, Sign_o, Eff_Sub_o
   );

endinterface

// File: rtl/exp_comparator.sv
// Combinational exponent comparator: ordering flags and both unsigned differences.
module exp_comparator
   import fpu_addsub_pkg::*;
(
   input  logic [EW-1:0] exp_a_i,
   input  logic [EW-1:0] exp_b_i,
   output logic          gt_o,
   output logic          eq_o,
   output logic [EW:0]   diff_ab_o,
   output logic [EW:0]   diff_ba_o
);

   always_comb begin
      gt_o      = exp_a_i > exp_b_i;
      eq_o      = exp_a_i == exp_b_i;
      diff_ab_o = {1'b0, exp_a_i} - {1'b0, exp_b_i};
      diff_ba_o = {1'b0, exp_b_i} - {1'b0, exp_a_i};
   end

endmodule

// File: rtl/exp_align_stage.sv
// Two-stage exponent alignment: S1 registers operands and exponent compare, S2 swaps and
// produces the saturated right-shift amount for the alignment shifter.
module exp_align_stage
   import fpu_addsub_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   exp_align_stage_if.slave bus
);

   logic adv;

   logic              s1_valid_d, s1_valid_q;
   logic [DW-1:0]     a_d, a_q, b_d, b_q;
   logic              gt_d, gt_q, eq_d, eq_q;
   logic [EW:0]       dab_d, dab_q, dba_d, dba_q;

   logic              cmp_gt, cmp_eq;
   logic [EW:0]       cmp_dab, cmp_dba;

   logic              valid_d, valid_q;
   logic [EW-1:0]     major_exp_d, major_exp_q;
   logic [SWR-1:0]    major_mant_d, major_mant_q;
   logic [SWR-1:0]    shift_data_d, shift_data_q;
   logic [EWR-1:0]    shift_value_d, shift_value_q;
   logic              sat_d, sat_q, swap_d, swap_q, sign_d, sign_q, eff_sub_d, eff_sub_q;

   logic              swap;
   logic [EW:0]       diff;
   logic [SW-1:0]     mant_a, mant_b;

   assign adv         = bus.ready_i | ~valid_q;
   assign bus.ready_o = adv;

   exp_comparator u_exp_comparator (
      .exp_a_i   (bus.Data_A_i[EXP_HI:EXP_LO]),
      .exp_b_i   (bus.Data_B_i[EXP_HI:EXP_LO]),
      .gt_o      (cmp_gt),
      .eq_o      (cmp_eq),
      .diff_ab_o (cmp_dab),
      .diff_ba_o (cmp_dba)
   );

   // S1: B carries its sign already adjusted by the operation.
   always_comb begin
      s1_valid_d = s1_valid_q;
      a_d        = a_q;
      b_d        = b_q;
      gt_d       = gt_q;
      eq_d       = eq_q;
      dab_d      = dab_q;
      dba_d      = dba_q;
      if (adv) begin
         s1_valid_d = bus.load_i;
         if (bus.load_i) begin
            a_d   = bus.Data_A_i;
            b_d   = {bus.Data_B_i[SIGN_BIT] ^ bus.Op_i, bus.Data_B_i[SIGN_BIT-1:0]};
            gt_d  = cmp_gt;
            eq_d  = cmp_eq;
            dab_d = cmp_dab;
            dba_d = cmp_dba;
         end
      end
   end

   // S2: a full magnitude tie keeps A as the major operand.
   always_comb begin
      mant_a = a_q[MANT_HI:MANT_LO];
      mant_b = b_q[MANT_HI:MANT_LO];
      swap   = ~gt_q & ~(eq_q & (mant_a >= mant_b));
      diff   = swap ? dba_q : dab_q;

      valid_d       = valid_q;
      major_exp_d   = major_exp_q;
      major_mant_d  = major_mant_q;
      shift_data_d  = shift_data_q;
      shift_value_d = shift_value_q;
      sat_d         = sat_q;
      swap_d        = swap_q;
      sign_d        = sign_q;
      eff_sub_d     = eff_sub_q;
      if (adv) begin
         valid_d       = s1_valid_q;
         sat_d         = diff > DIFF_W'(SWR);
         shift_value_d = sat_d ? EWR'(SWR) : diff[EWR-1:0];
         swap_d        = swap;
         major_exp_d   = swap ? b_q[EXP_HI:EXP_LO] : a_q[EXP_HI:EXP_LO];
         major_mant_d  = mant_ext(swap ? mant_b : mant_a);
         shift_data_d  = mant_ext(swap ? mant_a : mant_b);
         sign_d        = swap ? b_q[SIGN_BIT] : a_q[SIGN_BIT];
         eff_sub_d     = a_q[SIGN_BIT] ^ b_q[SIGN_BIT];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q    <= 1'b0;
         a_q           <= '0;
         b_q           <= '0;
         gt_q          <= 1'b0;
         eq_q          <= 1'b0;
         dab_q         <= '0;
         dba_q         <= '0;
         valid_q       <= 1'b0;
         major_exp_q   <= '0;
         major_mant_q  <= '0;
         shift_data_q  <= '0;
         shift_value_q <= '0;
         sat_q         <= 1'b0;
         swap_q        <= 1'b0;
         sign_q        <= 1'b0;
         eff_sub_q     <= 1'b0;
      end else begin
         s1_valid_q    <= s1_valid_d;
         a_q           <= a_d;
         b_q           <= b_d;
         gt_q          <= gt_d;
         eq_q          <= eq_d;
         dab_q         <= dab_d;
         dba_q         <= dba_d;
         valid_q       <= valid_d;
         major_exp_q   <= major_exp_d;
         major_mant_q  <= major_mant_d;
         shift_data_q  <= shift_data_d;
         shift_value_q <= shift_value_d;
         sat_q         <= sat_d;
         swap_q        <= swap_d;
         sign_q        <= sign_d;
         eff_sub_q     <= eff_sub_d;
      end
   end

   assign bus.valid_o       = valid_q;
   assign bus.Major_Exp_o   = major_exp_q;
   assign bus.Major_Mant_o  = major_mant_q;
   assign bus.Shift_Data_o  = shift_data_q;
   assign bus.Shift_Value_o = shift_value_q;
   assign bus.Left_Right_o  = RIGHT;
   assign bus.Sat_o         = sat_q;
   assign bus.Swap_o        = swap_q;
   assign bus.Sign_o        = sign_q;
   assign bus.Eff_Sub_o     = eff_sub_q;

endmodule

// File: tb/tb_exp_align_stage.sv
// Self-checking bench for exp_align_stage: directed align cases plus randomized streams
// against a magnitude-based reference model and an in-order scoreboard.
module tb_exp_align_stage;
   import fpu_addsub_pkg::*;

   typedef struct packed {
      logic [7:0]  major_exp;
      logic [25:0] major_mant;
      logic [25:0] shift_data;
      logic [4:0]  shift_value;
      logic        sat;
      logic        swap;
      logic        sign;
      logic        eff_sub;
   } out_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   exp_align_stage_if bus ();

   exp_align_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Reference: larger magnitude wins, compared as a plain integer of exponent:mantissa.
   function automatic out_t model(input logic [31:0] a, input logic [31:0] b, input logic op);
      out_t        r;
      int          ea, eb, d;
      logic        swp;
      logic [22:0] maj, mnr;
      ea  = int'(a[30:23]);
      eb  = int'(b[30:23]);
      swp = b[30:0] > a[30:0];
      d   = swp ? eb - ea : ea - eb;
      maj = swp ? b[22:0] : a[22:0];
      mnr = swp ? a[22:0] : b[22:0];
      r.major_exp   = swp ? b[30:23] : a[30:23];
      r.major_mant  = {1'b1, maj, 2'b00};
      r.shift_data  = {1'b1, mnr, 2'b00};
      r.sat         = d > 26;
      r.shift_value = r.sat ? 5'd26 : 5'(d);
      r.swap        = swp;
      r.sign        = swp ? (b[31] ^ op) : a[31];
      r.eff_sub     = a[31] ^ b[31] ^ op;
      return r;
   endfunction

   function automatic out_t grab();
      out_t r;
      r.major_exp   = bus.Major_Exp_o;
      r.major_mant  = bus.Major_Mant_o;
      r.shift_data  = bus.Shift_Data_o;
      r.shift_value = bus.Shift_Value_o;
      r.sat         = bus.Sat_o;
      r.swap        = bus.Swap_o;
      r.sign        = bus.Sign_o;
      r.eff_sub     = bus.Eff_Sub_o;
      return r;
   endfunction

   function automatic logic [63:0] gen_pair();
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
         0: b[30:23] = a[30:23] + 8'($urandom_range(0, 30));
         1: b[30:23] = a[30:23] - 8'($urandom_range(0, 30));
         2: b[30:0] = a[30:0];
         default: ;
      endcase
      return {a, b};
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One isolated transfer with ready_i held high; checks latency and the full model.
   task automatic xfer(input logic [31:0] a, input logic [31:0] b, input logic op,
                       output out_t got);
      out_t exp;
      exp = model(a, b, op);
      bus.load_i = 1'b1; bus.Data_A_i = a; bus.Data_B_i = b; bus.Op_i = op; bus.ready_i = 1'b1;
      #1;
      total++;
      if (bus.ready_o !== 1'b1) begin
         bad++; $display("FAIL xfer_ready got=%b want=1", bus.ready_o);
      end
      step();
      bus.load_i = 1'b0; bus.Data_A_i = $urandom; bus.Data_B_i = $urandom; bus.Op_i = $urandom;
      #1;
      total++;
      if (bus.valid_o !== 1'b0) begin
         bad++; $display("FAIL latency_early valid_o got=%b want=0", bus.valid_o);
      end
      step();
      #1;
      total++;
      if (bus.valid_o !== 1'b1) begin
         bad++; $display("FAIL latency valid_o got=%b want=1", bus.valid_o);
      end
      got = grab();
      total++;
      if (got !== exp) begin
         bad++; $display("FAIL model a=%h b=%h op=%b got=%h want=%h", a, b, op, got, exp);
      end
      step();
   endtask

   task automatic test_reset();
      out_t z;
      z = '0;
      bus.load_i = $urandom; bus.Op_i = $urandom; bus.ready_i = $urandom;
      bus.Data_A_i = $urandom; bus.Data_B_i = $urandom;
      repeat (3) step();
      #1;
      total++;
      if (bus.valid_o !== 1'b0) begin
         bad++; $display("FAIL reset_valid got=%b want=0", bus.valid_o);
      end
      total++;
      if ({grab(), bus.Left_Right_o} !== {z, 1'b0}) begin
         bad++; $display("FAIL reset_outputs got=%h want=0", {grab(), bus.Left_Right_o});
      end
      total++;
      if (bus.ready_o !== 1'b1) begin
         bad++; $display("FAIL reset_ready got=%b want=1", bus.ready_o);
      end
      @(negedge clk);
      rst = 1'b1; bus.load_i = 1'b0; bus.ready_i = 1'b1;
      repeat (3) begin
         step();
         #1;
         total++;
         if (bus.valid_o !== 1'b0) begin
            bad++; $display("FAIL idle_valid got=%b want=0", bus.valid_o);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_mid_reset();
      bus.ready_i = 1'b0; bus.load_i = 1'b1; bus.Op_i = 1'b0;
      bus.Data_A_i = 32'h41200000; bus.Data_B_i = 32'h3F800000;
      step();
      bus.Data_A_i = 32'h3F800000;
      step();
      #1;
      total++;
      if (bus.valid_o !== 1'b1 || bus.ready_o !== 1'b0) begin
         bad++; $display("FAIL pre_reset_stall valid=%b ready=%b want 1 0", bus.valid_o,
                         bus.ready_o);
      end
      #2 rst = 1'b0;
      #1;
      total++;
      if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
         bad++; $display("FAIL async_reset valid=%b ready=%b want 0 1", bus.valid_o,
                         bus.ready_o);
      end
      @(negedge clk);
      rst = 1'b1; bus.load_i = 1'b0; bus.ready_i = 1'b1;
      repeat (3) step();
      #1;
      total++;
      if (bus.valid_o !== 1'b0) begin
         bad++; $display("FAIL post_reset_valid got=%b want=0", bus.valid_o);
      end
      @(negedge clk);
   endtask

   task automatic test_basic();
      out_t g;
      xfer(32'h41200000, 32'h3F800000, 1'b0, g);
      total++;
      if ({g.swap, g.shift_value, g.major_exp, g.sat, g.eff_sub} !==
          {1'b0, 5'd3, 8'h82, 1'b0, 1'b0}) begin
         bad++; $display("FAIL basic_align got=%h want=%h",
                         {g.swap, g.shift_value, g.major_exp, g.sat, g.eff_sub},
                         {1'b0, 5'd3, 8'h82, 1'b0, 1'b0});
      end
   endtask

   task automatic test_swap_sign();
      out_t g;
      xfer(32'h3F800000, 32'hC1200000, 1'b0, g);
      total++;
      if ({g.swap, g.shift_value, g.sign, g.eff_sub} !== {1'b1, 5'd3, 1'b1, 1'b1}) begin
         bad++; $display("FAIL swap_add got=%h want=%h", {g.swap, g.shift_value, g.sign,
                         g.eff_sub}, {1'b1, 5'd3, 1'b1, 1'b1});
      end
      xfer(32'h3F800000, 32'hC1200000, 1'b1, g);
      total++;
      if ({g.swap, g.sign, g.eff_sub} !== {1'b1, 1'b0, 1'b0}) begin
         bad++; $display("FAIL swap_sub got=%b want=100", {g.swap, g.sign, g.eff_sub});
      end
   endtask

   task automatic test_equal_exp();
      out_t g;
      xfer(32'h3FC00000, 32'h3FA00000, 1'b0, g);
      total++;
      if ({g.swap, g.shift_value} !== {1'b0, 5'd0}) begin
         bad++; $display("FAIL eq_exp_noswap got=%h want=0", {g.swap, g.shift_value});
      end
      xfer(32'h3FA00000, 32'h3FC00000, 1'b0, g);
      total++;
      if ({g.swap, g.shift_value} !== {1'b1, 5'd0}) begin
         bad++; $display("FAIL eq_exp_swap got=%h want=20", {g.swap, g.shift_value});
      end
      xfer(32'h3FC00000, 32'h3FC00000, 1'b0, g);
      total++;
      if (g.swap !== 1'b0) begin
         bad++; $display("FAIL identical_swap got=%b want=0", g.swap);
      end
   endtask

   task automatic test_saturation();
      out_t g;
      xfer({1'b0, 8'h9B, 23'($urandom)}, {1'b1, 8'h80, 23'($urandom)}, 1'b0, g);
      total++;
      if ({g.shift_value, g.sat} !== {5'd26, 1'b1}) begin
         bad++; $display("FAIL sat_27 got=%h want=%h", {g.shift_value, g.sat}, {5'd26, 1'b1});
      end
      xfer({1'b0, 8'h9A, 23'($urandom)}, {1'b0, 8'h80, 23'($urandom)}, 1'b0, g);
      total++;
      if ({g.shift_value, g.sat} !== {5'd26, 1'b0}) begin
         bad++; $display("FAIL sat_26 got=%h want=%h", {g.shift_value, g.sat}, {5'd26, 1'b0});
      end
      xfer({1'b0, 8'h80, 23'($urandom)}, {1'b0, 8'h99, 23'($urandom)}, 1'b0, g);
      total++;
      if ({g.shift_value, g.sat, g.swap} !== {5'd25, 1'b0, 1'b1}) begin
         bad++; $display("FAIL sat_25 got=%h want=%h", {g.shift_value, g.sat, g.swap},
                         {5'd25, 1'b0, 1'b1});
      end
   endtask

   // Streams n pairs; ready_i forced low during cycles [st, st+sl), optionally random otherwise.
   task automatic stream(input int n, input int st, input int sl, input bit rnd);
      out_t        q[$];
      out_t        prev, e;
      logic [63:0] p;
      logic        op;
      int          sent, recv, cyc;
      bit          prev_stall, stall;
      sent = 0; recv = 0; cyc = 0; prev_stall = 1'b0; prev = '0;
      p = gen_pair(); op = $urandom;
      while (recv < n && cyc < 400) begin
         stall = (cyc >= st) && (cyc < st + sl);
         bus.load_i = (sent < n); bus.Data_A_i = p[63:32]; bus.Data_B_i = p[31:0]; bus.Op_i = op;
         bus.ready_i = stall ? 1'b0 : (rnd ? 1'($urandom) : 1'b1);
         #1;
         if (stall) begin
            total++;
            if (bus.ready_o !== 1'b0) begin
               bad++; $display("FAIL stall_ready cyc=%0d got=%b want=0", cyc, bus.ready_o);
            end
         end
         if (prev_stall && bus.valid_o) begin
            total++;
            if (grab() !== prev) begin
               bad++; $display("FAIL stall_hold cyc=%0d got=%h want=%h", cyc, grab(), prev);
            end
         end
         if (bus.valid_o && bus.ready_i) begin
            total++;
            if (q.size() == 0) begin
               bad++; $display("FAIL extra_output cyc=%0d got=%h want=none", cyc, grab());
            end else begin
               e = q.pop_front();
               if (grab() !== e) begin
                  bad++; $display("FAIL stream_order idx=%0d got=%h want=%h", recv, grab(), e);
               end
            end
            recv++;
         end
         if (bus.load_i && bus.ready_o) begin
            q.push_back(model(p[63:32], p[31:0], op));
            sent++;
            p = gen_pair(); op = $urandom;
         end
         prev_stall = bus.valid_o && !bus.ready_i;
         prev = grab();
         step();
         cyc++;
      end
      bus.load_i = 1'b0; bus.ready_i = 1'b1;
      #1;
      total++;
      if (recv != n || q.size() != 0) begin
         bad++; $display("FAIL stream_count got=%0d pending=%0d want=%0d pending=0", recv,
                         q.size(), n);
      end
      total++;
      if (bus.valid_o !== 1'b0) begin
         bad++; $display("FAIL stream_tail valid_o got=%b want=0", bus.valid_o);
      end
      step();
   endtask

   task automatic test_random();
      out_t        g;
      logic [63:0] p;
      repeat (30) begin
         p = gen_pair();
         xfer(p[63:32], p[31:0], 1'($urandom), g);
      end
   endtask

   task automatic test_back_to_back();
      stream(5, 3, 3, 1'b0);
      stream(60, -1, 0, 1'b1);
   endtask

   initial begin
      bus.load_i = 1'b0; bus.Op_i = 1'b0; bus.ready_i = 1'b0;
      bus.Data_A_i = '0; bus.Data_B_i = '0;
      @(negedge clk);
      test_reset();
      test_mid_reset();
      test_basic();
      test_swap_sign();
      test_equal_exp();
      test_saturation();
      test_random();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
